// File: rtl/vip_frame_ctrl.sv
// Frame-level controller for the vip chain: shadowed config committed at start of frame,
// frame geometry measurement and frame counting. Optional watchdog: define VIP_CTRL_WDOG_EN.
module vip_frame_ctrl #(
    parameter logic [7:0]  DEF_THRESHOLD = 8'd128,
    parameter logic [1:0]  DEF_MODE      = 2'd2,
    parameter logic [23:0] WDOG_CYCLES   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic        cfg_ack,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_hsync,
    input  logic        pre_frame_de,
    output logic [7:0]  act_threshold,
    output logic [1:0]  act_mode,
    output logic        proc_en,
    output logic        frame_start,
    output logic        frame_done,
    output logic [10:0] h_res,
    output logic [10:0] v_res,
    output logic [15:0] frame_cnt,
    output logic        cfg_pending,
    output logic        wdog_err
);
    localparam logic [10:0] CNT_MAX = 11'd2047;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_t;

    state_t      state;
    logic        vsync_q, vsync_d, de_q, de_d;
    logic        sof, eof, eol;
    logic        enable, single;
    logic [7:0]  thresh_sh;
    logic [1:0]  mode_sh;
    logic [10:0] pix_cnt, line_cnt;
    logic        commit, ctrl_wr, timeout;
    logic        unused_ok;

    // hsync is not needed: line ends are taken from the falling edge of de.
    assign unused_ok = ^{cfg_wdata[15:8], pre_frame_hsync};

    assign sof     = vsync_q & ~vsync_d;
    assign eof     = ~vsync_q & vsync_d;
    assign eol     = ~de_q & de_d;
    assign commit  = (state == WAIT_SOF) && enable && sof;
    assign ctrl_wr = cfg_wr && (cfg_addr == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            vsync_d <= 1'b0;
            de_q    <= 1'b0;
            de_d    <= 1'b0;
        end else begin
            vsync_q <= pre_frame_vsync;
            vsync_d <= vsync_q;
            de_q    <= pre_frame_de;
            de_d    <= de_q;
        end
    end

`ifdef VIP_CTRL_WDOG_EN
    logic [23:0] wdog_cnt;
    logic        wdog_flag;

    assign timeout = (state == WAIT_SOF || state == ACTIVE) && !sof && !eof
                     && (wdog_cnt == WDOG_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (sof || eof || timeout || !(state == WAIT_SOF || state == ACTIVE)) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 24'd1;
        end
    end

    // A timeout landing on the same cycle as a CTRL write still gets reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_flag <= 1'b0;
        end else if (timeout) begin
            wdog_flag <= 1'b1;
        end else if (ctrl_wr) begin
            wdog_flag <= 1'b0;
        end
    end

    assign wdog_err = wdog_flag;
`else
    logic unused_wdog;

    assign unused_wdog = ^WDOG_CYCLES;
    assign timeout     = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    // A write racing a commit keeps cfg_pending set so it is taken at the next sof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_sh   <= DEF_THRESHOLD;
            mode_sh     <= DEF_MODE;
            cfg_pending <= 1'b0;
            cfg_ack     <= 1'b0;
        end else begin
            cfg_ack <= cfg_wr;
            if (cfg_wr && cfg_addr == 2'd1) begin
                thresh_sh   <= cfg_wdata[7:0];
                cfg_pending <= 1'b1;
            end else if (cfg_wr && cfg_addr == 2'd2) begin
                mode_sh     <= cfg_wdata[1:0];
                cfg_pending <= 1'b1;
            end else if (commit) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            h_res    <= '0;
        end else if (commit) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (eol) begin
            h_res   <= pix_cnt;
            pix_cnt <= '0;
            if (line_cnt != CNT_MAX) begin
                line_cnt <= line_cnt + 11'd1;
            end
        end else if (de_q && pix_cnt != CNT_MAX) begin
            pix_cnt <= pix_cnt + 11'd1;
        end
    end

    // Leaving a single-shot frame also drops enable so the block stays parked in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            enable        <= 1'b0;
            single        <= 1'b0;
            act_threshold <= DEF_THRESHOLD;
            act_mode      <= DEF_MODE;
            proc_en       <= 1'b0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            v_res         <= '0;
            frame_cnt     <= '0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (commit) begin
                        state         <= ACTIVE;
                        act_threshold <= thresh_sh;
                        act_mode      <= mode_sh;
                        frame_start   <= 1'b1;
                        proc_en       <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (timeout) begin
                        state   <= WAIT_SOF;
                        proc_en <= 1'b0;
                    end else if (eof) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        v_res      <= line_cnt;
                        frame_cnt  <= frame_cnt + 16'd1;
                        proc_en    <= 1'b0;
                    end
                end
                DONE: begin
                    if (!enable || single) begin
                        state  <= IDLE;
                        enable <= enable & ~single;
                        single <= 1'b0;
                    end else begin
                        state <= WAIT_SOF;
                    end
                end
                default: state <= IDLE;
            endcase
            if (ctrl_wr) begin
                enable <= cfg_wdata[0];
                single <= cfg_wdata[1];
            end
        end
    end

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Directed self-checking bench for vip_frame_ctrl: commit timing, geometry, single-shot,
// mid-frame enable/reset, watchdog (either build) and counter saturation.
module tb_vip_frame_ctrl;
    logic        clk;
    logic        rst_n;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_ack;
    logic        pre_frame_vsync;
    logic        pre_frame_hsync;
    logic        pre_frame_de;
    logic [7:0]  act_threshold;
    logic [1:0]  act_mode;
    logic        proc_en;
    logic        frame_start;
    logic        frame_done;
    logic [10:0] h_res;
    logic [10:0] v_res;
    logic [15:0] frame_cnt;
    logic        cfg_pending;
    logic        wdog_err;

    int errors = 0;
    int checks = 0;
    int start_seen = 0;
    int done_seen = 0;

    vip_frame_ctrl #(
        .DEF_THRESHOLD(8'd128),
        .DEF_MODE(2'd2),
        .WDOG_CYCLES(24'd100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_wr(cfg_wr),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_ack(cfg_ack),
        .pre_frame_vsync(pre_frame_vsync),
        .pre_frame_hsync(pre_frame_hsync),
        .pre_frame_de(pre_frame_de),
        .act_threshold(act_threshold),
        .act_mode(act_mode),
        .proc_en(proc_en),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .h_res(h_res),
        .v_res(v_res),
        .frame_cnt(frame_cnt),
        .cfg_pending(cfg_pending),
        .wdog_err(wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (frame_start === 1'b1) start_seen++;
        if (frame_done === 1'b1) done_seen++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        cfg_wr    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_wr    = 1'b0;
    endtask

    task automatic frame_begin();
        @(negedge clk);
        pre_frame_vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_line(input int pix);
        for (int i = 0; i < pix; i++) begin
            pre_frame_de    = 1'b1;
            pre_frame_hsync = 1'b1;
            @(negedge clk);
        end
        pre_frame_de    = 1'b0;
        pre_frame_hsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (2) @(negedge clk);
        pre_frame_vsync = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input int lines, input int pix);
        frame_begin();
        for (int l = 0; l < lines; l++) send_line(pix);
        frame_end();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (act_threshold !== 8'd128) begin errors++; $display("[TB] FAIL reset_thresh: got %0h expected 80", act_threshold); end
        checks++; if (act_mode !== 2'd2) begin errors++; $display("[TB] FAIL reset_mode: got %0d expected 2", act_mode); end
        checks++; if (proc_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_proc_en: got %b expected 0", proc_en); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (h_res !== 11'd0 || v_res !== 11'd0) begin errors++; $display("[TB] FAIL reset_res: got %0d/%0d expected 0/0", h_res, v_res); end
        checks++; if (cfg_pending !== 1'b0 || wdog_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b%b expected 00", cfg_pending, wdog_err); end
        checks++; if (frame_start !== 1'b0 || frame_done !== 1'b0 || cfg_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b%b%b expected 000", frame_start, frame_done, cfg_ack); end
    endtask

    task automatic test_basic_frame();
        int s0, d0;
        s0 = start_seen; d0 = done_seen;
        cfg_write(2'd0, 16'h0001);
        repeat (2) @(negedge clk);
        send_frame(4, 8);
        checks++; if (start_seen - s0 !== 1) begin errors++; $display("[TB] FAIL basic_start: got %0d expected 1", start_seen - s0); end
        checks++; if (done_seen - d0 !== 1) begin errors++; $display("[TB] FAIL basic_done: got %0d expected 1", done_seen - d0); end
        checks++; if (h_res !== 11'd8) begin errors++; $display("[TB] FAIL basic_h_res: got %0d expected 8", h_res); end
        checks++; if (v_res !== 11'd4) begin errors++; $display("[TB] FAIL basic_v_res: got %0d expected 4", v_res); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL basic_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (act_threshold !== 8'd128 || proc_en !== 1'b0) begin errors++; $display("[TB] FAIL basic_after: got thr=%0h en=%b expected 80/0", act_threshold, proc_en); end
    endtask

    task automatic test_mid_frame_write();
        frame_begin();
        send_line(8);
        checks++; if (proc_en !== 1'b1) begin errors++; $display("[TB] FAIL mid_proc_en: got %b expected 1", proc_en); end
        cfg_write(2'd1, 16'h0040);
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending_set: got %b expected 1", cfg_pending); end
        send_line(8);
        checks++; if (act_threshold !== 8'd128) begin errors++; $display("[TB] FAIL mid_thresh_held: got %0h expected 80", act_threshold); end
        frame_end();
        checks++; if (act_threshold !== 8'd128) begin errors++; $display("[TB] FAIL mid_thresh_gap: got %0h expected 80", act_threshold); end
        frame_begin();
        checks++; if (act_threshold !== 8'h40 || cfg_pending !== 1'b0) begin errors++; $display("[TB] FAIL mid_commit: got thr=%0h pend=%b expected 40/0", act_threshold, cfg_pending); end
        send_line(8);
        frame_end();
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("[TB] FAIL mid_frame_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_commit_collision();
        cfg_write(2'd1, 16'h0055);
        @(negedge clk);
        pre_frame_vsync = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'h0020;
        @(negedge clk);
        cfg_wr = 1'b0;
        checks++; if (act_threshold !== 8'h55) begin errors++; $display("[TB] FAIL collide_old: got %0h expected 55", act_threshold); end
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("[TB] FAIL collide_pending: got %b expected 1", cfg_pending); end
        send_line(4);
        frame_end();
        send_frame(1, 4);
        checks++; if (act_threshold !== 8'h20 || cfg_pending !== 1'b0) begin errors++; $display("[TB] FAIL collide_new: got thr=%0h pend=%b expected 20/0", act_threshold, cfg_pending); end
    endtask

    task automatic test_cfg_misc();
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 16'hFFFF;
        @(negedge clk);
        checks++; if (cfg_ack !== 1'b1) begin errors++; $display("[TB] FAIL ack_pulse: got %b expected 1", cfg_ack); end
        cfg_wr = 1'b0;
        @(negedge clk);
        checks++; if (cfg_ack !== 1'b0 || cfg_pending !== 1'b0) begin errors++; $display("[TB] FAIL addr3_effect: got ack=%b pend=%b expected 0/0", cfg_ack, cfg_pending); end
        cfg_write(2'd1, 16'hAB12);
        cfg_write(2'd2, 16'hFFF1);
        checks++; if (cfg_pending !== 1'b1 || act_mode !== 2'd2) begin errors++; $display("[TB] FAIL misc_pending: got pend=%b mode=%0d expected 1/2", cfg_pending, act_mode); end
        send_frame(1, 3);
        checks++; if (act_threshold !== 8'h12 || act_mode !== 2'd1) begin errors++; $display("[TB] FAIL misc_commit: got thr=%0h mode=%0d expected 12/1", act_threshold, act_mode); end
        checks++; if (h_res !== 11'd3 || v_res !== 11'd1) begin errors++; $display("[TB] FAIL misc_res: got %0d/%0d expected 3/1", h_res, v_res); end
    endtask

    task automatic test_enable_mid_frame();
        int s0, d0;
        do_reset();
        s0 = start_seen; d0 = done_seen;
        frame_begin();
        send_line(8);
        cfg_write(2'd0, 16'h0001);
        repeat (5) @(negedge clk);
        send_line(8);
        checks++; if (start_seen - s0 !== 0 || proc_en !== 1'b0) begin errors++; $display("[TB] FAIL join_mid: got starts=%0d en=%b expected 0/0", start_seen - s0, proc_en); end
        frame_end();
        checks++; if (done_seen - d0 !== 0) begin errors++; $display("[TB] FAIL join_done: got %0d expected 0", done_seen - d0); end
        send_frame(2, 4);
        checks++; if (start_seen - s0 !== 1 || done_seen - d0 !== 1) begin errors++; $display("[TB] FAIL join_next: got %0d/%0d expected 1/1", start_seen - s0, done_seen - d0); end
        checks++; if (frame_cnt !== 16'd1 || v_res !== 11'd2 || h_res !== 11'd4) begin errors++; $display("[TB] FAIL join_geom: got cnt=%0d v=%0d h=%0d expected 1/2/4", frame_cnt, v_res, h_res); end
    endtask

    task automatic test_single_shot();
        int s0, d0;
        do_reset();
        s0 = start_seen; d0 = done_seen;
        cfg_write(2'd0, 16'h0003);
        repeat (2) @(negedge clk);
        for (int f = 0; f < 3; f++) send_frame(2, 4);
        checks++; if (done_seen - d0 !== 1 || start_seen - s0 !== 1) begin errors++; $display("[TB] FAIL single_pulses: got %0d/%0d expected 1/1", start_seen - s0, done_seen - d0); end
        checks++; if (frame_cnt !== 16'd1 || proc_en !== 1'b0) begin errors++; $display("[TB] FAIL single_cnt: got cnt=%0d en=%b expected 1/0", frame_cnt, proc_en); end
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        cfg_write(2'd1, 16'h0033);
        cfg_write(2'd0, 16'h0001);
        repeat (2) @(negedge clk);
        frame_begin();
        send_line(4);
        checks++; if (act_threshold !== 8'h33 || proc_en !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre: got thr=%0h en=%b expected 33/1", act_threshold, proc_en); end
        rst_n = 1'b0;
        #1;
        checks++; if (act_threshold !== 8'd128 || proc_en !== 1'b0 || frame_cnt !== 16'd0 || h_res !== 11'd0) begin errors++; $display("[TB] FAIL rmid_async: got thr=%0h en=%b cnt=%0d h=%0d expected 80/0/0/0", act_threshold, proc_en, frame_cnt, h_res); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = start_seen;
        cfg_write(2'd0, 16'h0001);
        send_line(4);
        checks++; if (start_seen - s0 !== 0) begin errors++; $display("[TB] FAIL rmid_wait: got %0d expected 0", start_seen - s0); end
        frame_end();
        send_frame(1, 4);
        checks++; if (start_seen - s0 !== 1 || frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rmid_next: got starts=%0d cnt=%0d expected 1/1", start_seen - s0, frame_cnt); end
    endtask

    task automatic test_watchdog();
        int d0;
        d0 = done_seen;
        frame_begin();
        send_line(4);
        repeat (150) @(negedge clk);
`ifdef VIP_CTRL_WDOG_EN
        checks++; if (wdog_err !== 1'b1 || proc_en !== 1'b0) begin errors++; $display("[TB] FAIL wdog_fire: got err=%b en=%b expected 1/0", wdog_err, proc_en); end
        frame_end();
        checks++; if (done_seen - d0 !== 0 || frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL wdog_no_done: got done=%0d cnt=%0d expected 0/1", done_seen - d0, frame_cnt); end
        cfg_write(2'd0, 16'h0001);
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("[TB] FAIL wdog_clear: got %b expected 0", wdog_err); end
`else
        checks++; if (wdog_err !== 1'b0 || proc_en !== 1'b1) begin errors++; $display("[TB] FAIL wdog_off: got err=%b en=%b expected 0/1", wdog_err, proc_en); end
        frame_end();
        checks++; if (done_seen - d0 !== 1 || frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL wdog_off_done: got done=%0d cnt=%0d expected 1/2", done_seen - d0, frame_cnt); end
`endif
    endtask

    task automatic test_saturation();
        do_reset();
        send_line(2050);
        @(negedge clk);
        checks++; if (h_res !== 11'd2047) begin errors++; $display("[TB] FAIL sat_h_res: got %0d expected 2047", h_res); end
    endtask

    initial begin
        rst_n           = 1'b1;
        cfg_wr          = 1'b0;
        cfg_addr        = 2'd0;
        cfg_wdata       = 16'h0000;
        pre_frame_vsync = 1'b0;
        pre_frame_hsync = 1'b0;
        pre_frame_de    = 1'b0;
        test_reset();
        test_basic_frame();
        test_mid_frame_write();
        test_commit_collision();
        test_cfg_misc();
        test_enable_mid_frame();
        test_single_shot();
        test_reset_mid_frame();
        test_watchdog();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
